// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_sequencer
// Description : Master-mode SPI transfer engine. Captures a frame and the
//               CR1/BR configuration on start, then generates SS/SCLK/MOSI,
//               samples MISO and returns the received frame with a 1-cycle
//               rec_data_o pulse.
// Ports       : pclk, preset_n                  - clock, async active-low reset
//               send_data_i, mosi_data_i        - start request and tx frame
//               mstr_i, cpol_i, cpha_i, lsbfe_i - mode / framing config
//               sppr_i, spr_i                   - baud divider select
//               spi_mode_i                      - 00 run, 01 wait, 10 stop
//               miso_i                          - serial data in
//               sclk_o, ss_o, mosi_o            - SPI pins
//               tip_o, rec_data_o, miso_data_o  - status and received frame
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 11
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              send_data_i,
    input  logic [DATA_W-1:0] mosi_data_i,
    input  logic              mstr_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic [2:0]        sppr_i,
    input  logic [2:0]        spr_i,
    input  logic [1:0]        spi_mode_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              ss_o,
    output logic              mosi_o,
    output logic              tip_o,
    output logic              rec_data_o,
    output logic [DATA_W-1:0] miso_data_o
);

    localparam int c_EDGE_W = $clog2(2*DATA_W + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEAD  = 3'd1;
    localparam logic [2:0] c_XFER  = 3'd2;
    localparam logic [2:0] c_TRAIL = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2*DATA_W - 1);
    localparam logic [1:0]          c_MODE_STOP = 2'b10;

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_half;
    logic [c_EDGE_W-1:0] r_edge;   // edges already produced in this frame
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsbfe;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_sclk;
    logic                r_ss;
    logic                r_mosi;
    logic                r_tip;
    logic                r_rec_data;
    logic [DATA_W-1:0]   r_miso_data;

    logic [CNT_W-1:0]    w_half;
    logic                w_stop;
    logic                w_start;
    logic                w_cnt_end;
    logic                w_last_edge;
    logic                w_sample;
    logic                w_advance;

    // Half period in pclk cycles: (sppr+1) << spr, range 1..1024.
    assign w_half      = (CNT_W'(sppr_i) + CNT_W'(1)) << spr_i;
    assign w_stop      = (spi_mode_i == c_MODE_STOP);
    assign w_start     = send_data_i & mstr_i & ~w_stop;
    assign w_cnt_end   = (r_cnt == r_half - CNT_W'(1));
    assign w_last_edge = (r_edge == c_LAST_EDGE);

    // The edge being produced is k = r_edge + 1, so k is odd when r_edge is even.
    // cpha=0: sample on odd k, shift out on even k except the final edge.
    // cpha=1: shift out on odd k except the first edge, sample on even k.
    assign w_sample  = r_cpha ? r_edge[0] : ~r_edge[0];
    assign w_advance = r_cpha ? (~r_edge[0] && (r_edge != '0))
                              : (r_edge[0] && !w_last_edge);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_half      <= CNT_W'(1);
            r_edge      <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_lsbfe     <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_sclk      <= 1'b0;
            r_ss        <= 1'b1;
            r_mosi      <= 1'b0;
            r_tip       <= 1'b0;
            r_rec_data  <= 1'b0;
            r_miso_data <= '0;
        end else begin
            r_rec_data <= 1'b0;
            if ((r_state != c_IDLE) && !mstr_i) begin
                // Abort: drop the frame without publishing received data.
                r_state <= c_IDLE;
                r_ss    <= 1'b1;
                r_tip   <= 1'b0;
                r_sclk  <= cpol_i;
                r_cnt   <= '0;
                r_edge  <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_ss   <= 1'b1;
                        r_tip  <= 1'b0;
                        r_sclk <= cpol_i;
                        r_cnt  <= '0;
                        r_edge <= '0;
                        if (w_start) begin
                            r_state <= c_LEAD;
                            r_ss    <= 1'b0;
                            r_tip   <= 1'b1;
                            r_half  <= w_half;
                            r_cpol  <= cpol_i;
                            r_cpha  <= cpha_i;
                            r_lsbfe <= lsbfe_i;
                            r_tx    <= mosi_data_i;
                            r_rx    <= '0;
                            r_mosi  <= lsbfe_i ? mosi_data_i[0]
                                               : mosi_data_i[DATA_W-1];
                        end
                    end
                    c_LEAD: begin
                        if (!w_stop) begin
                            if (w_cnt_end) begin
                                r_cnt   <= '0;
                                r_state <= c_XFER;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    c_XFER: begin
                        if (!w_stop) begin
                            if (w_cnt_end) begin
                                r_cnt  <= '0;
                                r_sclk <= ~r_sclk;
                                r_edge <= r_edge + c_EDGE_W'(1);
                                if (w_sample) begin
                                    r_rx <= r_lsbfe ? {miso_i, r_rx[DATA_W-1:1]}
                                                    : {r_rx[DATA_W-2:0], miso_i};
                                end
                                if (w_advance) begin
                                    r_tx   <= r_lsbfe ? (r_tx >> 1) : (r_tx << 1);
                                    r_mosi <= r_lsbfe ? r_tx[1] : r_tx[DATA_W-2];
                                end
                                if (w_last_edge) begin
                                    r_state <= c_TRAIL;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    c_TRAIL: begin
                        r_sclk <= r_cpol;
                        if (!w_stop) begin
                            if (w_cnt_end) begin
                                r_cnt   <= '0;
                                r_state <= c_DONE;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    c_DONE: begin
                        // tip stays high through this cycle; status flips on exit.
                        r_state     <= c_IDLE;
                        r_ss        <= 1'b1;
                        r_tip       <= 1'b0;
                        r_rec_data  <= 1'b1;
                        r_miso_data <= r_rx;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign sclk_o      = r_sclk;
    assign ss_o        = r_ss;
    assign mosi_o      = r_mosi;
    assign tip_o       = r_tip;
    assign rec_data_o  = r_rec_data;
    assign miso_data_o = r_miso_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_sequencer
// Description : Directed self-checking bench for spi_xfer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sequencer;

    logic       pclk;
    logic       preset_n;
    logic       send_data_i;
    logic [7:0] mosi_data_i;
    logic       mstr_i;
    logic       cpol_i;
    logic       cpha_i;
    logic       lsbfe_i;
    logic [2:0] sppr_i;
    logic [2:0] spr_i;
    logic [1:0] spi_mode_i;
    logic       miso_i;
    logic       sclk_o;
    logic       ss_o;
    logic       mosi_o;
    logic       tip_o;
    logic       rec_data_o;
    logic [7:0] miso_data_o;

    logic loop_en;
    logic miso_tie;
    assign miso_i = loop_en ? mosi_o : miso_tie;

    spi_xfer_sequencer #(.DATA_W(8), .CNT_W(11)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .send_data_i (send_data_i),
        .mosi_data_i (mosi_data_i),
        .mstr_i      (mstr_i),
        .cpol_i      (cpol_i),
        .cpha_i      (cpha_i),
        .lsbfe_i     (lsbfe_i),
        .sppr_i      (sppr_i),
        .spr_i       (spr_i),
        .spi_mode_i  (spi_mode_i),
        .miso_i      (miso_i),
        .sclk_o      (sclk_o),
        .ss_o        (ss_o),
        .mosi_o      (mosi_o),
        .tip_o       (tip_o),
        .rec_data_o  (rec_data_o),
        .miso_data_o (miso_data_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_total = 0;
    int n_pass  = 0;

    // Line monitor, sampled on the falling edge of pclk.
    int       cyc = 0;
    int       tip_cnt, rec_cnt, tog_cnt;
    int       gap_min, gap_max, last_tog;
    int       ss_hi, last_ss_gap;
    logic [7:0] mosi_odd, mosi_even;
    logic     sclk_prev = 1'b0;

    always @(negedge pclk) begin
        cyc = cyc + 1;
        if (tip_o === 1'b1) tip_cnt = tip_cnt + 1;
        if (rec_data_o === 1'b1) rec_cnt = rec_cnt + 1;
        if ((sclk_o !== sclk_prev) && (tip_o === 1'b1)) begin
            tog_cnt = tog_cnt + 1;
            if (tog_cnt[0]) mosi_odd  = {mosi_odd[6:0], mosi_o};
            else            mosi_even = {mosi_even[6:0], mosi_o};
            if (tog_cnt > 1) begin
                if (cyc - last_tog < gap_min) gap_min = cyc - last_tog;
                if (cyc - last_tog > gap_max) gap_max = cyc - last_tog;
            end
            last_tog = cyc;
        end
        sclk_prev = sclk_o;
        if (ss_o === 1'b1) begin
            ss_hi = ss_hi + 1;
        end else begin
            if (ss_hi > 0) last_ss_gap = ss_hi;
            ss_hi = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic clr_mon();
        tip_cnt     = 0;
        rec_cnt     = 0;
        tog_cnt     = 0;
        gap_min     = 1000000;
        gap_max     = 0;
        last_tog    = 0;
        mosi_odd    = '0;
        mosi_even   = '0;
    endtask

    task automatic start_frame(input string tag);
        int n = 0;
        send_data_i = 1'b1;
        while ((tip_o !== 1'b1) && (n < 10)) begin step(); n++; end
        chk(tag, {31'd0, tip_o}, 32'd1);
        send_data_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((tip_o !== 1'b0) && (n < budget)) begin step(); n++; end
        chk(tag, {31'd0, tip_o}, 32'd0);
    endtask

    task automatic wait_tog(input string tag, input int target, input int budget);
        int n = 0;
        while ((tog_cnt < target) && (n < budget)) begin step(); n++; end
        chk(tag, tog_cnt, target);
    endtask

    initial begin
        preset_n    = 1'b0;
        send_data_i = 1'b0;
        mosi_data_i = 8'h00;
        mstr_i      = 1'b1;
        cpol_i      = 1'b0;
        cpha_i      = 1'b0;
        lsbfe_i     = 1'b0;
        sppr_i      = 3'd0;
        spr_i       = 3'd0;
        spi_mode_i  = 2'b00;
        loop_en     = 1'b1;
        miso_tie    = 1'b0;
        ss_hi       = 0;
        last_ss_gap = 0;
        clr_mon();
        repeat (3) step();

        // Reset values
        chk("rst_ss",   {31'd0, ss_o},       32'd1);
        chk("rst_sclk", {31'd0, sclk_o},     32'd0);
        chk("rst_mosi", {31'd0, mosi_o},     32'd0);
        chk("rst_tip",  {31'd0, tip_o},      32'd0);
        chk("rst_rec",  {31'd0, rec_data_o}, 32'd0);
        chk("rst_data", {24'd0, miso_data_o}, 32'd0);
        preset_n = 1'b1;
        repeat (2) step();

        // H=1, cpol0 cpha0 msb-first, A5 looped back
        mosi_data_i = 8'hA5;
        clr_mon();
        start_frame("t1_start");
        wait_idle("t1_done", 100);
        chk("t1_toggles", tog_cnt, 32'd16);
        chk("t1_mosi",    {24'd0, mosi_odd}, 32'hA5);
        chk("t1_rec",     rec_cnt, 32'd1);
        chk("t1_data",    {24'd0, miso_data_o}, 32'hA5);
        chk("t1_tip",     tip_cnt, 32'd19);
        chk("t1_ss",      {31'd0, ss_o}, 32'd1);

        // H=6, cpol1 cpha1 lsb-first, 3C out, miso tied high; config
        // changed mid-frame must not take effect
        loop_en  = 1'b0;
        miso_tie = 1'b1;
        sppr_i   = 3'd2;
        spr_i    = 3'd1;
        cpol_i   = 1'b1;
        cpha_i   = 1'b1;
        lsbfe_i  = 1'b1;
        mosi_data_i = 8'h3C;
        repeat (2) step();
        chk("t2_idle_sclk", {31'd0, sclk_o}, 32'd1);
        clr_mon();
        start_frame("t2_start");
        sppr_i = 3'd0;
        spr_i  = 3'd0;
        cpha_i = 1'b0;
        lsbfe_i = 1'b0;
        mosi_data_i = 8'h00;
        wait_idle("t2_done", 300);
        chk("t2_toggles", tog_cnt, 32'd16);
        chk("t2_gap_min", gap_min, 32'd6);
        chk("t2_gap_max", gap_max, 32'd6);
        chk("t2_mosi",    {24'd0, mosi_even}, 32'h3C);
        chk("t2_data",    {24'd0, miso_data_o}, 32'hFF);
        chk("t2_tip",     tip_cnt, 32'd109);
        chk("t2_rec",     rec_cnt, 32'd1);

        // Stop mode for 20 cycles after edge 5, H=1, 5A looped back
        loop_en = 1'b1;
        cpol_i  = 1'b0;
        repeat (2) step();
        mosi_data_i = 8'h5A;
        clr_mon();
        start_frame("t3_start");
        wait_tog("t3_edge5", 5, 50);
        spi_mode_i = 2'b10;
        begin
            logic s_hold;
            s_hold = sclk_o;
            repeat (20) step();
            chk("t3_frozen_tog",  tog_cnt, 32'd5);
            chk("t3_frozen_sclk", {31'd0, sclk_o}, {31'd0, s_hold});
            chk("t3_frozen_ss",   {31'd0, ss_o}, 32'd0);
        end
        spi_mode_i = 2'b00;
        wait_idle("t3_done", 100);
        chk("t3_data", {24'd0, miso_data_o}, 32'h5A);
        chk("t3_tip",  tip_cnt, 32'd39);
        chk("t3_rec",  rec_cnt, 32'd1);

        // Abort by dropping mstr at edge 9, H=2
        sppr_i = 3'd1;
        mosi_data_i = 8'hC3;
        clr_mon();
        start_frame("t4_start");
        wait_tog("t4_edge9", 9, 100);
        mstr_i = 1'b0;
        step();
        chk("t4_ss",   {31'd0, ss_o},   32'd1);
        chk("t4_tip",  {31'd0, tip_o},  32'd0);
        chk("t4_sclk", {31'd0, sclk_o}, 32'd0);
        repeat (40) step();
        chk("t4_rec",  rec_cnt, 32'd0);
        chk("t4_data", {24'd0, miso_data_o}, 32'h5A);
        mstr_i = 1'b1;
        step();

        // send_data held high: back-to-back frames, H=1
        sppr_i = 3'd0;
        mosi_data_i = 8'h96;
        clr_mon();
        send_data_i = 1'b1;
        begin
            int n = 0;
            while ((rec_cnt < 2) && (n < 48)) begin step(); n++; end
        end
        send_data_i = 1'b0;
        chk("t5_two_frames", rec_cnt, 32'd2);
        chk("t5_ss_gap", {31'd0, (last_ss_gap >= 1)}, 32'd1);
        chk("t5_data", {24'd0, miso_data_o}, 32'h96);
        wait_idle("t5_done", 100);

        // Start request while in stop mode and idle is ignored
        spi_mode_i  = 2'b10;
        send_data_i = 1'b1;
        clr_mon();
        repeat (20) step();
        chk("t5_stop_tip", tip_cnt, 32'd0);
        chk("t5_stop_ss",  {31'd0, ss_o}, 32'd1);
        send_data_i = 1'b0;
        spi_mode_i  = 2'b00;
        step();

        // Asynchronous reset mid-transfer, H=4, cpol1, FF out
        sppr_i = 3'd3;
        cpol_i = 1'b1;
        mosi_data_i = 8'hFF;
        repeat (2) step();
        clr_mon();
        start_frame("t6_start");
        wait_tog("t6_edge3", 3, 100);
        preset_n = 1'b0;
        #1;
        chk("t6_ss",   {31'd0, ss_o},       32'd1);
        chk("t6_sclk", {31'd0, sclk_o},     32'd0);
        chk("t6_mosi", {31'd0, mosi_o},     32'd0);
        chk("t6_tip",  {31'd0, tip_o},      32'd0);
        chk("t6_rec",  {31'd0, rec_data_o}, 32'd0);
        chk("t6_data", {24'd0, miso_data_o}, 32'd0);
        step();
        preset_n = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
